// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding and HD44780 command bytes for the LCD bar-graph controller.
package lcd_pkg;
   typedef enum logic [2:0] {INIT, CFG, IDLE, LATCH, P_POS, P_DIG, V_POS, V_BAR} lcdState_t;
   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_LINE1    = 8'h80;
   localparam logic [7:0] CMD_LINE2    = 8'hC0;
   localparam logic [7:0] ASCII_ZERO   = 8'h30;
endpackage

// File: rtl/lcd_bin2ascii3.sv
// lcd_bin2ascii3: combinational 8-bit binary to three ASCII decimal digits (double-dabble).
module lcd_bin2ascii3
   import lcd_pkg::*;
(
   input  logic [7:0] bin,
   output logic [7:0] hundreds,
   output logic [7:0] tens,
   output logic [7:0] units
);
   logic [11:0] bcd;
   always_comb begin
      bcd = '0;
      for (int i = 7; i >= 0; i--) begin
         for (int d = 0; d < 3; d++)
            if (bcd[4*d +: 4] > 4'd4) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
         bcd = {bcd[10:0], bin[i]};
      end
   end
   assign hundreds = ASCII_ZERO + {4'd0, bcd[11:8]};
   assign tens     = ASCII_ZERO + {4'd0, bcd[7:4]};
   assign units    = ASCII_ZERO + {4'd0, bcd[3:0]};
endmodule

// File: rtl/lcd_bar_ctrl.sv
// lcd_bar_ctrl: HD44780 power-up configuration, then per SPI update draws the channel
// number as three digits on line 1 and the channel value as a bar graph on line 2.
module lcd_bar_ctrl
   import lcd_pkg::*;
#(
   parameter int         VAL_W          = 8,
   parameter int         BAR_COLS       = 16,
   parameter int         INIT_CYCLES    = 800,
   parameter logic [7:0] FULL_CHAR      = 8'hFF,
   parameter logic [7:0] EMPTY_CHAR     = 8'h20,
   parameter bit         SKIP_UNCHANGED = 1'b1
) (
   input  logic             int_osc,
   input  logic             reset,
   input  logic             en,
   input  logic [7:0]       param,
   input  logic [VAL_W-1:0] value,
   input  logic             SPIDone,
   input  logic             dataDone,
   output logic             dataReady,
   output logic             RSin,
   output logic             RWin,
   output logic [7:0]       dataIn,
   output logic             busy
);
   localparam int CW = $clog2(INIT_CYCLES + 1);
   localparam int STEP = (2 ** VAL_W) / BAR_COLS;

   lcdState_t        state, nextState;
   logic [CW-1:0]    initCnt;
   logic [3:0]       idx;
   logic             pending, drawnValid;
   logic [7:0]       curParam, drawnParam;
   logic [VAL_W-1:0] curValue, drawnValue;
   logic [23:0]      digits;
   logic [7:0]       hund, tens, units, curByte;
   logic [VAL_W:0]   thresh;
   logic             barHit, curRs, lastByte, skipNow;

   lcd_bin2ascii3 u_conv (.bin(param), .hundreds(hund), .tens(tens), .units(units));

   // Column thresholds are compared one bit wider than the value so k*STEP never wraps.
   assign thresh  = (VAL_W+1)'(idx) * (VAL_W+1)'(STEP);
   assign barHit  = {1'b0, curValue} > thresh;
   assign curByte = (state == CFG) ? (idx == 4'd0 ? CMD_FUNC_SET : idx == 4'd1 ? CMD_ENTRY : CMD_DISP_ON)
                  : (state == P_POS) ? CMD_LINE1
                  : (state == P_DIG) ? (idx == 4'd0 ? digits[23:16] : idx == 4'd1 ? digits[15:8] : digits[7:0])
                  : (state == V_POS) ? CMD_LINE2
                  : (barHit ? FULL_CHAR : EMPTY_CHAR);
   assign curRs     = (state == P_DIG) || (state == V_BAR);
   assign lastByte  = (state == CFG || state == P_DIG) ? idx == 4'd2
                    : (state == V_BAR) ? idx == 4'(BAR_COLS - 1) : 1'b1;
   assign nextState = (state == CFG) ? IDLE : (state == P_POS) ? P_DIG : (state == P_DIG) ? V_POS
                    : (state == V_POS) ? V_BAR : IDLE;
   assign skipNow   = SKIP_UNCHANGED && drawnValid && param == drawnParam && value == drawnValue;
   assign RWin      = 1'b0;

   always_ff @(posedge int_osc or negedge reset) begin
      if (!reset) begin
         state      <= INIT;
         initCnt    <= '0;
         idx        <= '0;
         pending    <= 1'b0;
         drawnValid <= 1'b0;
         curParam   <= '0;
         curValue   <= '0;
         drawnParam <= '0;
         drawnValue <= '0;
         digits     <= '0;
         dataIn     <= '0;
         dataReady  <= 1'b0;
         RSin       <= 1'b0;
         busy       <= 1'b1;
      end else if (en) begin
         if (SPIDone && state != IDLE && state != LATCH) pending <= 1'b1;
         case (state)
            INIT: begin
               initCnt <= initCnt + CW'(1);
               if (initCnt == CW'(INIT_CYCLES - 1)) state <= CFG;
            end
            IDLE: if (SPIDone || pending) begin
               state <= LATCH;
               busy  <= 1'b1;
            end
            LATCH: begin
               pending  <= SPIDone;
               curParam <= param;
               curValue <= value;
               digits   <= {hund, tens, units};
               if (skipNow) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state     <= P_POS;
                  dataIn    <= CMD_LINE1;
                  RSin      <= 1'b0;
                  dataReady <= 1'b1;
               end
            end
            default: if (!dataReady) begin
               dataIn    <= curByte;
               RSin      <= curRs;
               dataReady <= 1'b1;
            end else if (dataDone) begin
               dataReady <= 1'b0;
               idx       <= lastByte ? 4'd0 : idx + 4'd1;
               if (lastByte) begin
                  state <= nextState;
                  busy  <= nextState != IDLE;
               end
               if (lastByte && state == V_BAR) begin
                  drawnValid <= 1'b1;
                  drawnParam <= curParam;
                  drawnValue <= curValue;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_bar_ctrl.sv
// tb_lcd_bar_ctrl: table-driven check of config, digit/bar drawing, skip, pending, reset and enable.
module tb_lcd_bar_ctrl;
   typedef struct {
      logic [7:0]  p;
      logic [7:0]  v;
      logic [23:0] dig;
      int          full;
   } vec_t;

   logic       clk = 1'b0;
   logic [1:0] rstn = 2'b00;
   logic       en = 1'b1;
   logic [7:0] param = '0, value = '0;
   logic [1:0] spi = '0, done = '0, rdy, rs, rw, bsy;
   logic       manDone = 1'b0, autoResp = 1'b1, sel = 1'b1;
   logic [7:0] din0, din1;
   logic       curRdy, curRs, curBusy;
   logic [7:0] curDin;
   logic [8:0] logQ[$], expQ[$];
   int         riseQ[$], gapQ[$];
   int         cyc = 0, spiCyc = 0, lowCnt = 0, rwBad = 0, nCmp = 0, nErr = 0;
   int         rcnt[2];
   logic       prevRdy = 1'b0, spiBusy;
   vec_t       tbl[5];

   always #5 clk = ~clk;

   lcd_bar_ctrl #(.INIT_CYCLES(16), .SKIP_UNCHANGED(1'b1)) dut (
      .int_osc(clk), .reset(rstn[1]), .en(en), .param(param), .value(value), .SPIDone(spi[1]),
      .dataDone(done[1] | manDone), .dataReady(rdy[1]), .RSin(rs[1]), .RWin(rw[1]), .dataIn(din1),
      .busy(bsy[1]));

   lcd_bar_ctrl #(.INIT_CYCLES(16), .SKIP_UNCHANGED(1'b0)) dutNoSkip (
      .int_osc(clk), .reset(rstn[0]), .en(en), .param(param), .value(value), .SPIDone(spi[0]),
      .dataDone(done[0]), .dataReady(rdy[0]), .RSin(rs[0]), .RWin(rw[0]), .dataIn(din0),
      .busy(bsy[0]));

   assign curRdy  = sel ? rdy[1] : rdy[0];
   assign curRs   = sel ? rs[1] : rs[0];
   assign curDin  = sel ? din1 : din0;
   assign curBusy = sel ? bsy[1] : bsy[0];

   always @(posedge clk) cyc++;

   // LCD writer model: answer dataDone three cycles after dataReady rises.
   always @(negedge clk)
      for (int i = 0; i < 2; i++) begin
         if (!autoResp) begin
            rcnt[i] = 0;
            done[i] = 1'b0;
         end else if (done[i]) begin
            done[i] = 1'b0;
            rcnt[i] = 0;
         end else if (rdy[i]) begin
            rcnt[i]++;
            if (rcnt[i] == 3) done[i] = 1'b1;
         end else rcnt[i] = 0;
      end

   always begin
      @(posedge clk);
      #3;
      if (curRdy && !prevRdy) begin
         logQ.push_back({curRs, curDin});
         riseQ.push_back(cyc);
         gapQ.push_back(lowCnt);
      end
      lowCnt  = curRdy ? 0 : lowCnt + 1;
      prevRdy = curRdy;
      if (rw != 2'b00) rwBad++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic addCfg();
      expQ.push_back({1'b0, 8'h38});
      expQ.push_back({1'b0, 8'h06});
      expQ.push_back({1'b0, 8'h0C});
   endtask

   task automatic addUpd(input logic [23:0] dig, input int full);
      expQ.push_back({1'b0, 8'h80});
      for (int i = 0; i < 3; i++) expQ.push_back({1'b1, dig[23-8*i -: 8]});
      expQ.push_back({1'b0, 8'hC0});
      for (int k = 0; k < 16; k++) expQ.push_back({1'b1, (k < full) ? 8'hFF : 8'h20});
   endtask

   task automatic clearLog();
      logQ.delete();
      riseQ.delete();
      gapQ.delete();
      expQ.delete();
   endtask

   task automatic checkLog(input string nm);
      chk({nm, "_len"}, logQ.size(), expQ.size());
      for (int i = 0; i < logQ.size() && i < expQ.size(); i++)
         chk($sformatf("%s_b%0d", nm, i), int'(logQ[i]), int'(expQ[i]));
   endtask

   task automatic waitIdle(input string nm, output int hi);
      int q = 0;
      hi = 0;
      for (int i = 0; i < 3000 && q < 4; i++) begin
         @(negedge clk);
         if (curBusy) begin
            hi++;
            q = 0;
         end else q++;
      end
      chk({nm, "_done"}, (q >= 4) ? 1 : 0, 1);
   endtask

   task automatic pulse(input logic [7:0] p, input logic [7:0] v);
      @(negedge clk);
      param = p;
      value = v;
      spi[sel] = 1'b1;
      spiCyc = cyc;
      @(negedge clk);
      spi = '0;
      spiBusy = curBusy;
   endtask

   task automatic runUpd(input logic [7:0] p, input logic [7:0] v, input logic [23:0] dig,
                         input int full, input string nm);
      int hi, bad;
      clearLog();
      addUpd(dig, full);
      pulse(p, v);
      waitIdle(nm, hi);
      checkLog(nm);
      if (riseQ.size() > 0) chk({nm, "_lat"}, riseQ[0] - spiCyc, 2);
      bad = 0;
      for (int i = 1; i < gapQ.size(); i++) if (gapQ[i] != 1) bad++;
      chk({nm, "_gap"}, bad, 0);
   endtask

   task automatic waitLog(input int n, input string nm);
      int i = 0;
      while (logQ.size() < n && i < 500) begin
         @(negedge clk);
         i++;
      end
      chk({nm, "_reached"}, (logQ.size() >= n) ? 1 : 0, 1);
   endtask

   initial begin
      int hi, bad;
      tbl[0] = '{8'd255, 8'd255, "255", 16};
      tbl[1] = '{8'd0,   8'd0,   "000", 0};
      tbl[2] = '{8'd128, 8'd16,  "128", 1};
      tbl[3] = '{8'd99,  8'd17,  "099", 2};
      tbl[4] = '{8'd5,   8'd54,  "005", 4};

      repeat (2) @(negedge clk);
      chk("rst_dataIn", din1, 0);
      chk("rst_dataReady", rdy[1], 0);
      chk("rst_RSin", rs[1], 0);
      chk("rst_RWin", rw[1], 0);
      chk("rst_busy", bsy[1], 1);
      rstn[1] = 1'b1;
      clearLog();
      addCfg();
      waitIdle("cfg", hi);
      checkLog("cfg");
      chk("cfg_busy", bsy[1], 0);

      for (int i = 0; i < 5; i++)
         runUpd(tbl[i].p, tbl[i].v, tbl[i].dig, tbl[i].full, $sformatf("vec%0d", i));

      // identical update is skipped: LATCH only, no bytes
      clearLog();
      pulse(8'd5, 8'd54);
      chk("skip_busy1", spiBusy, 1);
      waitIdle("skip", hi);
      chk("skip_busy_extra", hi, 0);
      chk("skip_nbytes", logQ.size(), 0);

      // three strobes during an update collapse into one follow-up
      clearLog();
      addUpd("001", 1);
      addUpd("009", 13);
      pulse(8'd1, 8'd1);
      waitLog(5, "pend");
      param = 8'd9;
      value = 8'd200;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         spi[1] = 1'b1;
         @(negedge clk);
         spi[1] = 1'b0;
         repeat (3) @(negedge clk);
      end
      waitIdle("pend", hi);
      checkLog("pend");

      // async reset during the bar, then redraw of the last drawn values must happen
      clearLog();
      pulse(8'd7, 8'd100);
      waitLog(10, "rstmid");
      @(negedge clk);
      #2 rstn[1] = 1'b0;
      #1;
      chk("rstmid_dataReady", rdy[1], 0);
      chk("rstmid_dataIn", din1, 0);
      chk("rstmid_RSin", rs[1], 0);
      chk("rstmid_busy", bsy[1], 1);
      @(negedge clk);
      clearLog();
      addCfg();
      rstn[1] = 1'b1;
      waitIdle("recfg", hi);
      checkLog("recfg");
      runUpd(8'd9, 8'd200, "009", 13, "redraw");

      // en=0 freezes a pending byte and ignores dataDone
      autoResp = 1'b0;
      clearLog();
      addUpd("003", 16);
      pulse(8'd3, 8'd250);
      @(negedge clk);
      chk("frz_ready0", rdy[1], 1);
      en = 1'b0;
      manDone = 1'b1;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (rdy[1] !== 1'b1 || din1 !== 8'h80 || rs[1] !== 1'b0 || bsy[1] !== 1'b1) bad++;
      end
      chk("frz_held", bad, 0);
      manDone = 1'b0;
      en = 1'b1;
      repeat (2) @(negedge clk);
      chk("frz_still_ready", rdy[1], 1);
      chk("frz_still_byte", din1, 8'h80);
      autoResp = 1'b1;
      waitIdle("frz", hi);
      checkLog("frz");

      // no-skip instance: strobe during INIT is served after config, then identical redraw
      sel = 1'b0;
      @(negedge clk);
      clearLog();
      addCfg();
      addUpd("005", 4);
      rstn[0] = 1'b1;
      repeat (3) @(negedge clk);
      pulse(8'd5, 8'd54);
      waitIdle("initpend", hi);
      checkLog("initpend");
      runUpd(8'd5, 8'd54, "005", 4, "noskip");

      chk("rw_never_high", rwBad, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end
endmodule
